// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: exception_type / exc_flags bit positions,
// the default exception vector, FSM state encoding and the interrupt-pending helper.
package exc_ctrl_pkg;

    localparam int EXC_TYPE_W  = 9;
    localparam int EXC_FLAGS_W = 8;

    // exception_type one-hot positions
    localparam int ET_INT  = 0;
    localparam int ET_IF   = 1;
    localparam int ET_RI   = 2;
    localparam int ET_OV   = 3;
    localparam int ET_BP   = 4;
    localparam int ET_SYS  = 5;
    localparam int ET_ADEL = 6;
    localparam int ET_ADES = 7;
    localparam int ET_ERET = 8;

    // exc_flags indices
    localparam int EF_IF   = 0;
    localparam int EF_RI   = 1;
    localparam int EF_OV   = 2;
    localparam int EF_BP   = 3;
    localparam int EF_SYS  = 4;
    localparam int EF_ADEL = 5;
    localparam int EF_ADES = 6;
    localparam int EF_ERET = 7;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } exc_state_e;

    // An interrupt is pending only when globally enabled, not already in exception level,
    // and at least one unmasked line is raised in Cause.IP.
    function automatic logic calc_int_pend(input logic       ie,
                                           input logic       exl,
                                           input logic [7:0] im,
                                           input logic [7:0] ip);
        return ie & ~exl & (|(ip & im));
    endfunction

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// Combinational priority encoder: exc_flags plus interrupt-pending to a one-hot exception_type.
// Order high->low: INT, fetch AdEL, RI, OV, BP, SYS, AdEL, AdES, ERET.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic [EXC_FLAGS_W-1:0] exc_flags,
    input  logic                   int_pend,
    output logic [EXC_TYPE_W-1:0]  exc_type
);

    // Pick the highest-priority event; none yields all zeros.
    always_comb begin
        exc_type = {EXC_TYPE_W{1'b0}};
        if (int_pend) begin
            exc_type[ET_INT] = 1'b1;
        end else if (exc_flags[EF_IF]) begin
            exc_type[ET_IF] = 1'b1;
        end else if (exc_flags[EF_RI]) begin
            exc_type[ET_RI] = 1'b1;
        end else if (exc_flags[EF_OV]) begin
            exc_type[ET_OV] = 1'b1;
        end else if (exc_flags[EF_BP]) begin
            exc_type[ET_BP] = 1'b1;
        end else if (exc_flags[EF_SYS]) begin
            exc_type[ET_SYS] = 1'b1;
        end else if (exc_flags[EF_ADEL]) begin
            exc_type[ET_ADEL] = 1'b1;
        end else if (exc_flags[EF_ADES]) begin
            exc_type[ET_ADES] = 1'b1;
        end else if (exc_flags[EF_ERET]) begin
            exc_type[ET_ERET] = 1'b1;
        end else begin
            exc_type = {EXC_TYPE_W{1'b0}};
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between MEM and CP0: commit, flush, then redirect fetch.
// Optional macro EXC_CTRL_INT_SYNC_EN adds an INT_SYNC_STAGES flop chain on hw_int.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEF,
    parameter int          FLUSH_CYCLES    = 2,
    parameter int          INT_SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exc_valid,
    input  logic [7:0]            exc_flags,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_delayslot,
    input  logic [31:0]           exc_badvaddr,
    input  logic [31:0]           cp0_status,
    input  logic [31:0]           cp0_cause,
    input  logic [31:0]           cp0_epc,
    input  logic [4:0]            hw_int,
    output logic [4:0]            int_to_cp0,
    output logic [EXC_TYPE_W-1:0] exception_type,
    output logic [31:0]           cp0_current_pc,
    output logic                  cp0_delayslot,
    output logic [31:0]           cp0_badvaddr,
    output logic                  flush,
    output logic                  busy,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    input  logic                  redirect_ready
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic                  int_pend_s;
    logic                  event_s;
    logic [EXC_TYPE_W-1:0] type_s;
    logic                  unused_s;

    exc_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           target_q, target_d;

    logic [EXC_TYPE_W-1:0] exception_type_q, exception_type_d;
    logic [31:0]           cp0_current_pc_q, cp0_current_pc_d;
    logic                  cp0_delayslot_q, cp0_delayslot_d;
    logic [31:0]           cp0_badvaddr_q, cp0_badvaddr_d;
    logic                  flush_q, flush_d;
    logic                  busy_q, busy_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [31:0]           redirect_pc_q, redirect_pc_d;

    assign int_pend_s = calc_int_pend(cp0_status[0], cp0_status[1],
                                      cp0_status[15:8], cp0_cause[15:8]);
    assign event_s    = exc_valid & (int_pend_s | (|exc_flags));
    assign unused_s   = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

    exc_prio_enc u_prio (
        .exc_flags (exc_flags),
        .int_pend  (int_pend_s),
        .exc_type  (type_s)
    );

    // Next-state and next-output logic; outputs are registered from the values computed here.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        target_d         = target_q;
        exception_type_d = {EXC_TYPE_W{1'b0}};
        cp0_current_pc_d = 32'h0000_0000;
        cp0_delayslot_d  = 1'b0;
        cp0_badvaddr_d   = 32'h0000_0000;
        flush_d          = 1'b0;
        busy_d           = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (event_s) begin
                    state_d          = ST_FLUSH;
                    cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
                    // EPC is captured now so a later CP0 write cannot move the return target.
                    target_d         = type_s[ET_ERET] ? cp0_epc : EXC_VECTOR;
                    exception_type_d = type_s;
                    cp0_current_pc_d = exc_pc;
                    cp0_delayslot_d  = exc_delayslot;
                    cp0_badvaddr_d   = type_s[ET_IF] ? exc_pc : exc_badvaddr;
                    flush_d          = 1'b1;
                    busy_d           = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                busy_d = 1'b1;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d          = ST_REDIR;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = target_q;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_d           = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = target_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= {CNT_W{1'b0}};
            target_q         <= 32'h0000_0000;
            exception_type_q <= {EXC_TYPE_W{1'b0}};
            cp0_current_pc_q <= 32'h0000_0000;
            cp0_delayslot_q  <= 1'b0;
            cp0_badvaddr_q   <= 32'h0000_0000;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            target_q         <= target_d;
            exception_type_q <= exception_type_d;
            cp0_current_pc_q <= cp0_current_pc_d;
            cp0_delayslot_q  <= cp0_delayslot_d;
            cp0_badvaddr_q   <= cp0_badvaddr_d;
            flush_q          <= flush_d;
            busy_q           <= busy_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign exception_type = exception_type_q;
    assign cp0_current_pc = cp0_current_pc_q;
    assign cp0_delayslot  = cp0_delayslot_q;
    assign cp0_badvaddr   = cp0_badvaddr_q;
    assign flush          = flush_q;
    assign busy           = busy_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef EXC_CTRL_INT_SYNC_EN
    logic [4:0] int_sync_q [INT_SYNC_STAGES];
    logic [4:0] int_sync_d [INT_SYNC_STAGES];

    // Shift chain feeding hw_int toward CP0.
    always_comb begin
        for (int i = 0; i < INT_SYNC_STAGES; i++) begin
            if (i == 0) begin
                int_sync_d[i] = hw_int;
            end else begin
                int_sync_d[i] = int_sync_q[i-1];
            end
        end
    end

    // Interrupt synchroniser flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < INT_SYNC_STAGES; i++) begin
                int_sync_q[i] <= 5'b0_0000;
            end
        end else begin
            for (int i = 0; i < INT_SYNC_STAGES; i++) begin
                int_sync_q[i] <= int_sync_d[i];
            end
        end
    end

    assign int_to_cp0 = int_sync_q[INT_SYNC_STAGES-1];
`else
    localparam int unused_sync_stages = INT_SYNC_STAGES;
    assign int_to_cp0 = hw_int;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, random transactions against a
// priority-list reference model, and hand sequences for reset, stall and interrupt forwarding.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    localparam int          FLUSH = 2;
    localparam logic [31:0] VEC   = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [7:0]  exc_flags;
    logic [31:0] exc_pc;
    logic        exc_delayslot;
    logic [31:0] exc_badvaddr;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [4:0]  hw_int;
    logic [4:0]  int_to_cp0;
    logic [8:0]  exception_type;
    logic [31:0] cp0_current_pc;
    logic        cp0_delayslot;
    logic [31:0] cp0_badvaddr;
    logic        flush;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_flags      (exc_flags),
        .exc_pc         (exc_pc),
        .exc_delayslot  (exc_delayslot),
        .exc_badvaddr   (exc_badvaddr),
        .cp0_status     (cp0_status),
        .cp0_cause      (cp0_cause),
        .cp0_epc        (cp0_epc),
        .hw_int         (hw_int),
        .int_to_cp0     (int_to_cp0),
        .exception_type (exception_type),
        .cp0_current_pc (cp0_current_pc),
        .cp0_delayslot  (cp0_delayslot),
        .cp0_badvaddr   (cp0_badvaddr),
        .flush          (flush),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    typedef struct {
        logic        v;
        logic [7:0]  f;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] pc;
        logic [31:0] bva;
        logic [31:0] epc;
        logic        ds;
        int          rdly;
        logic [8:0]  exp_type;
        logic [31:0] exp_bva;
        logic [31:0] exp_tgt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: candidates listed in priority order (INT first, then flags 0..7); first set one wins.
    function automatic logic [8:0] model_type(input logic v, input logic [7:0] f,
                                              input logic [31:0] st, input logic [31:0] ca);
        logic       ip;
        logic [8:0] cand;
        ip   = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
        cand = {f, ip};
        if (!v) return 9'h000;
        for (int i = 0; i < 9; i++) begin
            if (cand[i]) return 9'h001 << i;
        end
        return 9'h000;
    endfunction

    // Apply one MEM-stage instruction from IDLE and follow the whole sequence.
    task automatic run_txn(input vec_t t);
        exc_valid      = t.v;
        exc_flags      = t.f;
        cp0_status     = t.st;
        cp0_cause      = t.ca;
        exc_pc         = t.pc;
        exc_badvaddr   = t.bva;
        cp0_epc        = t.epc;
        exc_delayslot  = t.ds;
        redirect_ready = 1'b0;
        step();
        // competing event and EPC rewrite while busy must have no effect
        exc_valid     = 1'b1;
        exc_flags     = 8'h10;
        exc_pc        = 32'hDEAD_0000;
        exc_badvaddr  = 32'h0BAD_0000;
        cp0_epc       = 32'h1234_5678;
        exc_delayslot = ~t.ds;
        if (t.exp_type == 9'h000) begin
            chk("noevt_busy", {31'h0, busy}, 32'h0);
            chk("noevt_flush", {31'h0, flush}, 32'h0);
            chk("noevt_type", {23'h0, exception_type}, 32'h0);
            exc_valid = 1'b0;
            exc_flags = 8'h00;
            step();
            return;
        end
        chk("type_first", {23'h0, exception_type}, {23'h0, t.exp_type});
        chk("cur_pc", cp0_current_pc, t.pc);
        chk("delayslot", {31'h0, cp0_delayslot}, {31'h0, t.ds});
        chk("badvaddr", cp0_badvaddr, t.exp_bva);
        chk("flush_first", {31'h0, flush}, 32'h1);
        chk("busy_first", {31'h0, busy}, 32'h1);
        chk("rv_during_flush", {31'h0, redirect_valid}, 32'h0);
        for (int k = 1; k < FLUSH; k++) begin
            step();
            chk("flush_hold", {31'h0, flush}, 32'h1);
            chk("type_cleared", {23'h0, exception_type}, 32'h0);
            chk("cur_pc_cleared", cp0_current_pc, 32'h0);
            chk("rv_early", {31'h0, redirect_valid}, 32'h0);
        end
        step();
        chk("rv_rise", {31'h0, redirect_valid}, 32'h1);
        chk("redirect_pc", redirect_pc, t.exp_tgt);
        chk("flush_end", {31'h0, flush}, 32'h0);
        chk("busy_redir", {31'h0, busy}, 32'h1);
        for (int d = 0; d < t.rdly; d++) begin
            step();
            chk("rv_stall", {31'h0, redirect_valid}, 32'h1);
            chk("rpc_stall", redirect_pc, t.exp_tgt);
            chk("busy_stall", {31'h0, busy}, 32'h1);
        end
        redirect_ready = 1'b1;
        step();
        chk("rv_drop", {31'h0, redirect_valid}, 32'h0);
        chk("busy_drop", {31'h0, busy}, 32'h0);
        redirect_ready = 1'b0;
        exc_valid      = 1'b0;
        exc_flags      = 8'h00;
        step();
        chk("idle_after", {31'h0, busy}, 32'h0);
    endtask

    vec_t        vecs[11];
    vec_t        rv;
    logic [31:0] r0, r1, r2;

    initial begin
        rst = 1'b0; exc_valid = 1'b0; exc_flags = 8'h00; exc_pc = 32'h0;
        exc_delayslot = 1'b0; exc_badvaddr = 32'h0; cp0_status = 32'h0; cp0_cause = 32'h0;
        cp0_epc = 32'h0; hw_int = 5'h00; redirect_ready = 1'b0;

        #12;
        chk("rst_type", {23'h0, exception_type}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rv", {31'h0, redirect_valid}, 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0);
        chk("rst_bva", cp0_badvaddr, 32'h0);
        rst = 1'b1;
        step();
        chk("post_rst_busy", {31'h0, busy}, 32'h0);

        //            v     f      st            ca            pc            bva           epc           ds  rdly type    bva           tgt
        vecs[0]  = '{1'b1, 8'h10, 32'h0000_0000, 32'h0000_0000, 32'h8000_1000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 9'h020, 32'h0000_0000, VEC};
        vecs[1]  = '{1'b1, 8'h04, 32'h0000_FF01, 32'h0000_0400, 32'h8000_1100, 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 9'h001, 32'h0000_0000, VEC};
        vecs[2]  = '{1'b1, 8'h04, 32'h0000_FF03, 32'h0000_0400, 32'h8000_1104, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 9'h008, 32'h0000_0000, VEC};
        vecs[3]  = '{1'b1, 8'h80, 32'h0000_0000, 32'h0000_0000, 32'h8000_3000, 32'h0000_0000, 32'h8000_2004, 1'b0, 5, 9'h100, 32'h0000_0000, 32'h8000_2004};
        vecs[4]  = '{1'b1, 8'h01, 32'h0000_0000, 32'h0000_0000, 32'h8000_0003, 32'h0000_5555, 32'h0000_0000, 1'b0, 0, 9'h002, 32'h8000_0003, VEC};
        vecs[5]  = '{1'b1, 8'h40, 32'h0000_0000, 32'h0000_0000, 32'h8000_0010, 32'h0000_1001, 32'h0000_0000, 1'b1, 2, 9'h080, 32'h0000_1001, VEC};
        vecs[6]  = '{1'b1, 8'h00, 32'h0000_FB01, 32'h0000_0400, 32'h8000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 9'h000, 32'h0000_0000, VEC};
        vecs[7]  = '{1'b0, 8'hFF, 32'h0000_FF01, 32'h0000_FF00, 32'h8000_0024, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 9'h000, 32'h0000_0000, VEC};
        vecs[8]  = '{1'b1, 8'h0A, 32'h0000_0000, 32'h0000_0000, 32'h8000_0028, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 9'h004, 32'h0000_0000, VEC};
        vecs[9]  = '{1'b1, 8'hA0, 32'h0000_0000, 32'h0000_0000, 32'h8000_002C, 32'h0000_7777, 32'h8000_9000, 1'b0, 1, 9'h040, 32'h0000_7777, VEC};
        vecs[10] = '{1'b1, 8'h08, 32'h0000_FF00, 32'h0000_0400, 32'h8000_0030, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 9'h010, 32'h0000_0000, VEC};
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i]);
        end

        for (int i = 0; i < 60; i++) begin
            r0 = $urandom;
            r1 = $urandom;
            r2 = $urandom;
            rv.v    = ($urandom_range(0, 7) != 0);
            rv.f    = (r0[31:30] == 2'b00) ? 8'h00 : (r0[7:0] & r0[15:8]);
            rv.st   = {16'h0000, r1[7:0], 6'b00_0000, r1[9:8]};
            rv.ca   = {16'h0000, r1[23:16] & r1[31:24], 8'h00};
            rv.pc   = {r2[31:2], 2'b00} ^ {30'h0, r0[17:16]};
            rv.bva  = $urandom;
            rv.epc  = $urandom;
            rv.ds   = r0[20];
            rv.rdly = $urandom_range(0, 3);
            rv.exp_type = model_type(rv.v, rv.f, rv.st, rv.ca);
            rv.exp_bva  = rv.exp_type[ET_IF] ? rv.pc : rv.bva;
            rv.exp_tgt  = rv.exp_type[ET_ERET] ? rv.epc : VEC;
            run_txn(rv);
        end

        // reset while waiting in REDIR aborts without a redirect
        exc_valid = 1'b1; exc_flags = 8'h10; cp0_status = 32'h0; exc_pc = 32'h8000_4000;
        redirect_ready = 1'b0;
        step();
        exc_valid = 1'b0; exc_flags = 8'h00;
        step();
        step();
        chk("pre_rst_rv", {31'h0, redirect_valid}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_rv", {31'h0, redirect_valid}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_rpc", redirect_pc, 32'h0);
        #2;
        rst = 1'b1;
        step();
        step();
        chk("after_midrst_busy", {31'h0, busy}, 32'h0);
        chk("after_midrst_rv", {31'h0, redirect_valid}, 32'h0);
        chk("after_midrst_flush", {31'h0, flush}, 32'h0);

        // interrupt forwarding latency
        hw_int = 5'b00100;
        #1;
`ifdef EXC_CTRL_INT_SYNC_EN
        chk("int_sync_0", {27'h0, int_to_cp0}, 32'h0);
        step();
        chk("int_sync_1", {27'h0, int_to_cp0}, 32'h0);
        step();
        chk("int_sync_2", {27'h0, int_to_cp0}, 32'h4);
`else
        chk("int_comb", {27'h0, int_to_cp0}, 32'h4);
`endif
        hw_int = 5'b00000;
        step();
        step();
        step();
        chk("int_clear", {27'h0, int_to_cp0}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
